// File: rtl/relobi_xbar_map_cfg.sv
// relobi_xbar_map_cfg
// Configuration and scrubbing stage that feeds the reliable OBI crossbar.
// Keeps MapWidth redundant copies of the address map and the default-routing
// settings. A word-addressed register port writes all copies at once and
// reads back the voted value. A background scrubber walks every entry,
// repairs a single corrupted copy, and reports faults.
//
// Entry layout, E = 3*NumAddrRules + 1 + NumSbrPorts words:
//   3k   : rule k start_addr      3k+1 : rule k end_addr      3k+2 : rule k idx
//   3N   : en_default bits        3N+1+i : default_idx of subordinate port i
// Each word holds exactly one field, so comparing whole words compares
// fields.
//
// Rule packing on addr_map_o and in DefaultMap: {idx, start_addr, end_addr},
// with end_addr in the LSBs.
//
// Ports
//   clk_i, rst_ni            clock; synchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i   register access request (always granted)
//   cfg_gnt_o                grant, equal to cfg_req_i
//   cfg_rvalid_o/rdata_o/err_o      response, one cycle after grant
//   scrub_now_i              start a scrub pass now (ignored while busy)
//   scrub_busy_o             scrub pass in progress
//   addr_map_o, en_default_idx_o, default_idx_o   per-copy map to crossbar
//   fault_o                  bit0 corrected mismatch, bit1 uncorrectable
module relobi_xbar_map_cfg #(
    parameter int NumSbrPorts   = 1,
    parameter int NumMgrPorts   = 2,
    parameter int NumAddrRules  = 1,
    parameter int AddrWidth     = 32,
    parameter int MapWidth      = 3,
    parameter int ScrubInterval = 1024,
    parameter int IdxW          = $clog2(NumMgrPorts),
    parameter int RuleW         = IdxW + 2 * AddrWidth,
    parameter logic [NumAddrRules-1:0][RuleW-1:0] DefaultMap = '0
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           cfg_req_i,
    input  logic                                           cfg_we_i,
    input  logic [15:0]                                    cfg_addr_i,
    input  logic [31:0]                                    cfg_wdata_i,
    output logic                                           cfg_gnt_o,
    output logic                                           cfg_rvalid_o,
    output logic [31:0]                                    cfg_rdata_o,
    output logic                                           cfg_err_o,
    input  logic                                           scrub_now_i,
    output logic                                           scrub_busy_o,
    output logic [MapWidth-1:0][NumAddrRules-1:0][RuleW-1:0] addr_map_o,
    output logic [MapWidth-1:0][NumSbrPorts-1:0]           en_default_idx_o,
    output logic [MapWidth-1:0][NumSbrPorts-1:0][IdxW-1:0] default_idx_o,
    output logic [1:0]                                     fault_o
);

    localparam int E    = 3 * NumAddrRules + 1 + NumSbrPorts;
    localparam int EnW  = 3 * NumAddrRules;
    localparam int PtrW = $clog2(E);
    localparam int CntW = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;

    // Width of the field held in word w, as a right-aligned mask.
    function automatic logic [31:0] fmask(input int w);
        int fw;
        if (w < EnW)       fw = ((w % 3) == 2) ? IdxW : AddrWidth;
        else if (w == EnW) fw = NumSbrPorts;
        else               fw = IdxW;
        return (fw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << fw) - 32'd1);
    endfunction

    // Words holding a manager index must stay below NumMgrPorts.
    function automatic logic is_idx(input int w);
        if (w < EnW) return ((w % 3) == 2);
        return (w > EnW) && (w < E);
    endfunction

    typedef enum logic {ST_IDLE, ST_SCRUB} state_e;

    state_e                           r_state, w_state_nxt;
    logic [CntW-1:0]                  r_cnt, w_cnt_nxt;
    logic [PtrW-1:0]                  r_ptr, w_ptr_nxt;
    logic [MapWidth-1:0][E-1:0][31:0] r_ent, w_ent_nxt, w_ent_rst;
    logic [1:0]                       r_fault;
    logic                             r_rvalid, r_err;
    logic [31:0]                      r_rdata;

    logic [PtrW-1:0] w_aidx;
    logic            w_addr_ok, w_wbad, w_wr, w_collide, w_scrub_act, w_fix, w_unc, w_tick;
    logic [31:0]     w_wdat, w_rd_vote, w_sc_vote;
    logic            w_sc_corr, w_sc_unc;

    // ---------------- register port decode ----------------
    assign w_aidx    = cfg_addr_i[PtrW-1:0];
    assign w_addr_ok = (cfg_addr_i < 16'(E));
    // Index fields are range-checked on the full written word so that an
    // out-of-range index is rejected rather than silently wrapped.
    assign w_wbad    = is_idx(int'(w_aidx)) && (cfg_wdata_i >= 32'(NumMgrPorts));
    assign w_wr      = cfg_req_i && cfg_we_i && w_addr_ok && !w_wbad;
    assign w_wdat    = cfg_wdata_i & fmask(int'(w_aidx));
    assign cfg_gnt_o = cfg_req_i;

    // ---------------- voting ----------------
    if (MapWidth == 3) begin : g_tmr
        logic [31:0] w_ra, w_rb, w_rc, w_sa, w_sb, w_sc;
        logic        w_ab, w_ac, w_bc;
        assign w_ra = r_ent[0][w_aidx];
        assign w_rb = r_ent[1][w_aidx];
        assign w_rc = r_ent[2][w_aidx];
        assign w_sa = r_ent[0][r_ptr];
        assign w_sb = r_ent[1][r_ptr];
        assign w_sc = r_ent[2][r_ptr];
        assign w_ab = (w_sa == w_sb);
        assign w_ac = (w_sa == w_sc);
        assign w_bc = (w_sb == w_sc);
        assign w_rd_vote = (w_ra & w_rb) | (w_ra & w_rc) | (w_rb & w_rc);
        // With one field per word, two equal copies make the bitwise vote
        // equal to that pair, so the same vote serves as the repair value.
        assign w_sc_vote = (w_sa & w_sb) | (w_sa & w_sc) | (w_sb & w_sc);
        assign w_sc_corr = (w_ab || w_ac || w_bc) && !(w_ab && w_bc);
        assign w_sc_unc  = !(w_ab || w_ac || w_bc);
    end else begin : g_smp
        assign w_rd_vote = r_ent[0][w_aidx];
        assign w_sc_vote = r_ent[0][r_ptr];
        assign w_sc_corr = 1'b0;
        assign w_sc_unc  = 1'b0;
    end

    // ---------------- scrubber control ----------------
    assign w_scrub_act = (r_state == ST_SCRUB);
    // A same-cycle cfg write to the scrubbed entry overwrites every copy, so
    // the entry is treated as clean.
    assign w_collide   = w_wr && (w_aidx == r_ptr);
    assign w_fix       = w_scrub_act && w_sc_corr && !w_collide;
    assign w_unc       = w_scrub_act && w_sc_unc && !w_collide;
    assign w_tick      = (ScrubInterval != 0) && (r_cnt == CntW'(ScrubInterval - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if ((MapWidth == 3) && (scrub_now_i || w_tick)) begin
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = '0;
                    w_state_nxt = ST_SCRUB;
                end
            end
            ST_SCRUB: begin
                if (r_ptr == PtrW'(E - 1)) w_state_nxt = ST_IDLE;
                else                       w_ptr_nxt   = r_ptr + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ---------------- storage ----------------
    always_comb begin
        w_ent_rst = '0;
        for (int c = 0; c < MapWidth; c++) begin
            for (int k = 0; k < NumAddrRules; k++) begin
                w_ent_rst[c][3*k]   = 32'(DefaultMap[k][2*AddrWidth-1:AddrWidth]);
                w_ent_rst[c][3*k+1] = 32'(DefaultMap[k][AddrWidth-1:0]);
                w_ent_rst[c][3*k+2] = 32'(DefaultMap[k][RuleW-1:2*AddrWidth]);
            end
        end
    end

    // Cfg write is applied after the scrub repair so it wins on collision.
    always_comb begin
        w_ent_nxt = r_ent;
        if (w_fix) begin
            for (int c = 0; c < MapWidth; c++) w_ent_nxt[c][r_ptr] = w_sc_vote;
        end
        if (w_wr) begin
            for (int c = 0; c < MapWidth; c++) w_ent_nxt[c][w_aidx] = w_wdat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ent    <= w_ent_rst;
            r_fault  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ent    <= w_ent_nxt;
            r_fault  <= {w_unc, w_fix};
            r_rvalid <= cfg_req_i;
            r_err    <= cfg_req_i && (!w_addr_ok || (cfg_we_i && w_wbad));
            r_rdata  <= (cfg_req_i && !cfg_we_i && w_addr_ok) ? w_rd_vote : 32'd0;
        end
    end

    // ---------------- outputs ----------------
    for (genvar c = 0; c < MapWidth; c++) begin : g_out
        for (genvar k = 0; k < NumAddrRules; k++) begin : g_rule
            assign addr_map_o[c][k] = {r_ent[c][3*k+2][IdxW-1:0],
                                       r_ent[c][3*k][AddrWidth-1:0],
                                       r_ent[c][3*k+1][AddrWidth-1:0]};
        end
        assign en_default_idx_o[c] = r_ent[c][EnW][NumSbrPorts-1:0];
        for (genvar i = 0; i < NumSbrPorts; i++) begin : g_def
            assign default_idx_o[c][i] = r_ent[c][EnW+1+i][IdxW-1:0];
        end
    end

    assign scrub_busy_o = w_scrub_act;
    assign fault_o      = r_fault;
    assign cfg_rvalid_o = r_rvalid;
    assign cfg_err_o    = r_err;
    assign cfg_rdata_o  = r_rdata;

endmodule

// File: tb/tb_relobi_xbar_map_cfg.sv
// Self-checking bench for relobi_xbar_map_cfg. The reference model keeps
// each copy as a plain array of words and applies the register/scrub rules
// directly; copies are corrupted by forcing the DUT storage.
module tb_relobi_xbar_map_cfg;

    localparam int NS = 2, NM = 4, NR = 2, AW = 32, MW = 3, SI = 16;
    localparam int IW = 2, RW = IW + 2 * AW, E = 3 * NR + 1 + NS;
    localparam logic [NR-1:0][RW-1:0] DEF = {{2'd2, 32'h0000_0200, 32'h0000_02FF},
                                             {2'd1, 32'h0000_0100, 32'h0000_01FF}};

    logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, scrub_now = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic gnt, rvalid, err, busy;
    logic [31:0] rdata;
    logic [MW-1:0][NR-1:0][RW-1:0] amap;
    logic [MW-1:0][NS-1:0] endef;
    logic [MW-1:0][NS-1:0][IW-1:0] defidx;
    logic [1:0] fault;

    int n_chk = 0, n_fail = 0;
    logic [31:0] m [MW][E];
    logic [MW-1:0][E-1:0][31:0] f_img;

    always #5 clk = ~clk;

    relobi_xbar_map_cfg #(
        .NumSbrPorts(NS), .NumMgrPorts(NM), .NumAddrRules(NR), .AddrWidth(AW),
        .MapWidth(MW), .ScrubInterval(SI), .DefaultMap(DEF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
        .cfg_gnt_o(gnt), .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata), .cfg_err_o(err),
        .scrub_now_i(scrub_now), .scrub_busy_o(busy),
        .addr_map_o(amap), .en_default_idx_o(endef), .default_idx_o(defidx),
        .fault_o(fault)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] mask_of(input int w);
        if (w < 3 * NR) return ((w % 3) == 2) ? 32'((1 << IW) - 1) : 32'hFFFF_FFFF;
        if (w == 3 * NR) return 32'((1 << NS) - 1);
        return 32'((1 << IW) - 1);
    endfunction

    function automatic bit is_idx(input int w);
        if (w < 3 * NR) return ((w % 3) == 2);
        return (w > 3 * NR) && (w < E);
    endfunction

    // Most common value among the copies; with no agreeing pair, bitwise vote.
    function automatic logic [31:0] vote(input int w);
        if (m[0][w] == m[1][w] || m[0][w] == m[2][w]) return m[0][w];
        if (m[1][w] == m[2][w]) return m[1][w];
        return (m[0][w] & m[1][w]) | (m[0][w] & m[2][w]) | (m[1][w] & m[2][w]);
    endfunction

    task automatic model_reset;
        for (int c = 0; c < MW; c++) begin
            for (int w = 0; w < E; w++) m[c][w] = '0;
            for (int k = 0; k < NR; k++) begin
                m[c][3*k]   = DEF[k][2*AW-1:AW];
                m[c][3*k+1] = DEF[k][AW-1:0];
                m[c][3*k+2] = 32'(DEF[k][RW-1:2*AW]);
            end
        end
    endtask

    // One full scrub pass applied to the model; returns expected fault counts.
    task automatic model_scrub(output int ec, output int eu);
        ec = 0; eu = 0;
        for (int w = 0; w < E; w++) begin
            logic [31:0] a, b, c;
            a = m[0][w]; b = m[1][w]; c = m[2][w];
            if (a == b && b == c) continue;
            if (a == b || a == c) begin
                for (int k = 0; k < MW; k++) m[k][w] = a;
                ec++;
            end else if (b == c) begin
                for (int k = 0; k < MW; k++) m[k][w] = b;
                ec++;
            end else eu++;
        end
    endtask

    task automatic check_map(input string tag);
        for (int c = 0; c < MW; c++) begin
            for (int k = 0; k < NR; k++)
                chk($sformatf("%s.rule%0d.c%0d", tag, k, c), amap[c][k],
                    {m[c][3*k+2][IW-1:0], m[c][3*k], m[c][3*k+1]});
            chk($sformatf("%s.endef.c%0d", tag, c), endef[c], m[c][3*NR][NS-1:0]);
            for (int i = 0; i < NS; i++)
                chk($sformatf("%s.defidx%0d.c%0d", tag, i, c), defidx[c][i], m[c][3*NR+1+i][IW-1:0]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic xact(input bit w, input int a, input logic [31:0] d, input string tag);
        bit ce;
        logic [31:0] crd;
        ce  = (a >= E) || (w && is_idx(a) && d >= NM);
        crd = (!w && a < E) ? vote(a) : 32'd0;
        req = 1'b1; we = w; addr = 16'(a); wdata = d;
        #1;
        chk({tag, ".gnt"}, gnt, 1);
        tick;
        req = 1'b0; we = 1'b0;
        if (w && !ce) for (int c = 0; c < MW; c++) m[c][a] = d & mask_of(a);
        chk({tag, ".rvalid"}, rvalid, 1);
        chk({tag, ".err"}, err, ce);
        if (!w) chk({tag, ".rdata"}, rdata, crd);
    endtask

    // Overwrite one copy of one word directly in the DUT storage.
    task corrupt(input int c, input int w, input logic [31:0] v);
        for (int cc = 0; cc < MW; cc++)
            for (int ww = 0; ww < E; ww++) f_img[cc][ww] = m[cc][ww];
        f_img[c][w] = v;
        force dut.r_ent = f_img;
        tick;
        release dut.r_ent;
        m[c][w] = v;
    endtask

    // Trigger a pass from idle and watch it; a second scrub_now mid-pass
    // must not restart it.
    task automatic run_pass(output int nb, output int n01, output int n10);
        nb = 0; n01 = 0; n10 = 0;
        scrub_now = 1'b1;
        tick;
        scrub_now = 1'b0;
        for (int s = 0; s < 14; s++) begin
            if (busy) nb++;
            if (fault[0]) n01++;
            if (fault[1]) n10++;
            scrub_now = (s == 3);
            if (s < 13) tick;
        end
        scrub_now = 1'b0;
    endtask

    task automatic pass_check(input string tag);
        int nb, n01, n10, ec, eu;
        run_pass(nb, n01, n10);
        model_scrub(ec, eu);
        chk({tag, ".busy_cycles"}, nb, E);
        chk({tag, ".fault01"}, n01, ec);
        chk({tag, ".fault10"}, n10, eu);
        check_map(tag);
    endtask

    task automatic quiesce(input string tag);
        int g;
        g = 0;
        while (busy && g < 40) begin tick; g++; end
        chk({tag, ".idle"}, busy, 0);
        pass_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, nf;
        logic [31:0] v;

        // ---- reset state ----
        rst_n = 1'b0;
        tick; tick;
        model_reset();
        chk("rst.rvalid", rvalid, 0);
        chk("rst.err", err, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.busy", busy, 0);
        chk("rst.fault", fault, 0);
        chk("rst.gnt", gnt, 0);
        check_map("rst");
        rst_n = 1'b1;

        // ---- basic writes and read-back ----
        xact(1, 0, 32'h1000, "s1.w0");
        xact(1, 1, 32'h2000, "s1.w1");
        xact(1, 2, 32'd3, "s1.w2");
        xact(0, 2, 32'd0, "s1.r2");
        chk("s1.rdata3", rdata, 3);
        for (int c = 0; c < MW; c++)
            chk($sformatf("s1.rule0.c%0d", c), amap[c][0], {2'd3, 32'h1000, 32'h2000});

        // ---- rejected writes ----
        xact(1, 2, 32'd4, "s2.badidx");
        chk("s2.badidx_err", err, 1);
        xact(1, 9, 32'd5, "s2.oob");
        chk("s2.oob_err", err, 1);
        xact(0, 12, 32'd0, "s2.oob_rd");
        check_map("s2");

        // ---- single-copy corruption is repaired ----
        quiesce("s3.sync");
        corrupt(1, 0, 32'h1FFF);
        chk("s3.forced", amap[1][0][63:32], 32'h1FFF);
        pass_check("s3");
        chk("s3.restored", amap[1][0][63:32], 32'h1000);

        // ---- three-way difference is reported and left alone ----
        corrupt(0, 5, 32'd1);
        corrupt(1, 5, 32'd2);
        corrupt(2, 5, 32'd3);
        pass_check("s4");
        xact(0, 5, 32'd0, "s4.rd");
        chk("s4.vote3", rdata, 3);
        for (int c = 0; c < MW; c++)
            chk($sformatf("s4.idx.c%0d", c), amap[c][1][RW-1:2*AW], c + 1);
        xact(1, 5, 32'd2, "s4.fix");

        // ---- random register traffic with background scrubbing ----
        for (int i = 0; i < 80; i++) begin
            bit r, w, ce;
            int a;
            logic [31:0] d, crd;
            r = ($urandom_range(0, 4) != 0);
            w = 1'($urandom_range(0, 1));
            a = $urandom_range(0, E + 1);
            d = is_idx(a) ? 32'($urandom_range(0, 5)) : $urandom();
            ce  = (a >= E) || (w && is_idx(a) && d >= NM);
            crd = (!w && a < E) ? vote(a) : 32'd0;
            req = r; we = w; addr = 16'(a); wdata = d;
            #1;
            chk("rnd.gnt", gnt, r);
            tick;
            chk("rnd.rvalid", rvalid, r);
            if (r) chk($sformatf("rnd.err.a%0d", a), err, ce);
            if (r && !w) chk($sformatf("rnd.rdata.a%0d", a), rdata, crd);
            if (r && w && !ce) for (int c = 0; c < MW; c++) m[c][a] = d & mask_of(a);
            chk("rnd.fault", fault, 0);
            if (i % 16 == 15) check_map("rnd");
        end
        req = 1'b0; we = 1'b0;

        // ---- random corruptions ----
        for (int j = 0; j < 4; j++) begin
            int c1, w1, c2, w2;
            quiesce("rc.sync");
            c1 = $urandom_range(0, MW - 1);
            w1 = $urandom_range(0, E - 1);
            corrupt(c1, w1, m[c1][w1] ^ (($urandom() | 32'd1) & mask_of(w1)));
            if (j[0]) begin
                c2 = $urandom_range(0, MW - 1);
                w2 = $urandom_range(0, E - 1);
                if (w2 != w1) corrupt(c2, w2, m[c2][w2] ^ (($urandom() | 32'd1) & mask_of(w2)));
            end
            pass_check($sformatf("rc%0d", j));
        end

        // ---- automatic pass and write/scrub collision ----
        scrub_now = 1'b1;
        tick;
        scrub_now = 1'b0;
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        chk("s5.pass_end", busy, 0);
        n = 1;
        v = m[0][0];
        corrupt(1, 0, v ^ 32'h0000_00F0);
        while (!busy && n < 40) begin tick; n++; end
        chk("s5.interval", n, SI);
        v = $urandom();
        xact(1, 0, v, "s5.collide");
        nf = 0;
        for (int s = 0; s < 12; s++) begin
            if (fault != 2'b00) nf++;
            tick;
        end
        chk("s5.no_fault", nf, 0);
        for (int c = 0; c < MW; c++)
            chk($sformatf("s5.word0.c%0d", c), amap[c][0][63:32], v);
        check_map("s5");

        // ---- reset in the middle of a pass ----
        n = 0;
        while (busy && n < 40) begin tick; n++; end
        scrub_now = 1'b1;
        tick;
        scrub_now = 1'b0;
        tick; tick;
        chk("s6.mid_busy", busy, 1);
        rst_n = 1'b0;
        tick;
        model_reset();
        chk("s6.busy", busy, 0);
        chk("s6.fault", fault, 0);
        chk("s6.rvalid", rvalid, 0);
        check_map("s6");
        tick;
        rst_n = 1'b1;
        n = 0;
        do begin tick; n++; end while (!busy && n < 40);
        chk("s6.first_pass", n, SI);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
